pipe_ctrl: RTL and testbench

- Issue/sequencing controller for the 3-stage register-file/ALU datapath (DEC -> ALU -> WR).
- Accepts encoded instructions over a valid/ready handshake and drives register addresses, immediate, operand select, ALU function and write enable, each in its correct stage.
- Detects read-after-write hazards against in-flight writes and stalls by injecting bubbles; the datapath has no forwarding.
- Supports a drain request that empties the pipeline and reports idle.

---
 rtl/pipe_ctrl_pkg.sv | 45 ++++
 rtl/pipe_ctrl_hazard_detect.sv | 28 ++
 rtl/pipe_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and instruction field layout for the pipe_ctrl issue/sequencing controller.
// Optional stall counter is enabled by defining PIPE_CTRL_STALL_CNT_EN.
package pipe_ctrl_pkg;

  localparam int unsigned InstrW = 32;
  localparam int unsigned RegW   = 5;
  localparam int unsigned ImmW   = 16;

  localparam int unsigned FBit   = 31;
  localparam int unsigned RdLsb  = 26;
  localparam int unsigned RaLsb  = 21;
  localparam int unsigned RbLsb  = 16;
  localparam int unsigned ImmLsb = 0;

  typedef struct packed {
    logic            f;
    logic [RegW-1:0] rd;
    logic [RegW-1:0] ra;
    logic [RegW-1:0] rb;
    logic [ImmW-1:0] imm16;
  } instr_t;

  typedef struct packed {
    logic            valid;
    logic [RegW-1:0] rd;
    logic            f;
  } stage_t;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StDrain  = 2'd1,
    StHalted = 2'd2
  } state_t;

  function automatic instr_t decode_instr(input logic [InstrW-1:0] raw);
    instr_t d;
    d.f     = raw[FBit];
    d.rd    = raw[RdLsb +: RegW];
    d.ra    = raw[RaLsb +: RegW];
    d.rb    = raw[RbLsb +: RegW];
    d.imm16 = raw[ImmLsb +: ImmW];
    return d;
  endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Read-after-write hazard check of the DEC instruction against in-flight ALU/WR writes.
// The register file has no write-through, so a write in WR still blocks the read.
module pipe_ctrl_hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic            dec_valid_i,
  input  logic [RegW-1:0] dec_ra_i,
  input  logic [RegW-1:0] dec_rb_i,
  input  logic            dec_f_i,
  input  logic            alu_valid_i,
  input  logic [RegW-1:0] alu_rd_i,
  input  logic            wr_valid_i,
  input  logic [RegW-1:0] wr_rd_i,
  output logic            hazard_o
);

  logic ra_hit;
  logic rb_hit;

  assign ra_hit = (alu_valid_i && (alu_rd_i == dec_ra_i)) ||
                  (wr_valid_i  && (wr_rd_i  == dec_ra_i));
  assign rb_hit = (alu_valid_i && (alu_rd_i == dec_rb_i)) ||
                  (wr_valid_i  && (wr_rd_i  == dec_rb_i));

  // rb is only read when operand B comes from the register file (f = 0).
  assign hazard_o = dec_valid_i && (ra_hit || (!dec_f_i && rb_hit));

endmodule

// File: rtl/pipe_ctrl.sv
// Issue/sequencing controller for the DEC -> ALU -> WR register-file/ALU datapath.
// Define PIPE_CTRL_STALL_CNT_EN to add the saturating stall_count output.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned LENGTH   = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned SEL_BITS = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                instr_valid,
  input  logic [InstrW-1:0]   instr,
  output logic                instr_ready,
  input  logic                drain_req,
  output logic                idle,
  output logic [SEL_BITS-1:0] addr_a,
  output logic [SEL_BITS-1:0] addr_b,
  output logic [LENGTH-1:0]   imm,
  output logic                sel_imm,
  output logic                alu_f,
  output logic [SEL_BITS-1:0] addr_d,
  output logic                wr_regfile,
  output logic                stall
`ifdef PIPE_CTRL_STALL_CNT_EN
  ,
  output logic [15:0]         stall_count
`endif
);

  instr_t          dec_q, dec_d;
  logic            dec_valid_q, dec_valid_d;
  stage_t          alu_q, alu_d;
  logic            wr_valid_q, wr_valid_d;
  logic [RegW-1:0] wr_rd_q, wr_rd_d;
  state_t          state_q;
  logic            idle_q;

  logic hazard;
  logic accept;
  logic pipe_empty;

  pipe_ctrl_hazard_detect u_hazard_detect (
    .dec_valid_i (dec_valid_q),
    .dec_ra_i    (dec_q.ra),
    .dec_rb_i    (dec_q.rb),
    .dec_f_i     (dec_q.f),
    .alu_valid_i (alu_q.valid),
    .alu_rd_i    (alu_q.rd),
    .wr_valid_i  (wr_valid_q),
    .wr_rd_i     (wr_rd_q),
    .hazard_o    (hazard)
  );

  // drain_req blocks acceptance in the same cycle it rises, before the FSM leaves StRun.
  assign instr_ready = reset && (state_q == StRun) && !drain_req && (!dec_valid_q || !hazard);
  assign accept      = instr_valid && instr_ready;
  assign pipe_empty  = !dec_valid_q && !alu_q.valid && !wr_valid_q;

  always_comb begin
    wr_valid_d  = alu_q.valid;
    wr_rd_d     = alu_q.rd;
    alu_d       = '0;
    dec_valid_d = dec_valid_q;
    dec_d       = dec_q;
    if (!hazard) begin
      if (dec_valid_q) begin
        alu_d.valid = 1'b1;
        alu_d.rd    = dec_q.rd;
        alu_d.f     = dec_q.f;
      end
      dec_valid_d = accept;
      // DEC fields only change on a transfer so the DEC outputs hold across bubbles.
      if (accept) begin
        dec_d = decode_instr(instr);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dec_valid_q <= 1'b0;
      dec_q       <= '0;
      alu_q       <= '0;
      wr_valid_q  <= 1'b0;
      wr_rd_q     <= '0;
    end else begin
      dec_valid_q <= dec_valid_d;
      dec_q       <= dec_d;
      alu_q       <= alu_d;
      wr_valid_q  <= wr_valid_d;
      wr_rd_q     <= wr_rd_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StRun;
      idle_q  <= 1'b0;
    end else begin
      case (state_q)
        StRun: begin
          if (drain_req) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (!drain_req) begin
            state_q <= StRun;
          end else if (pipe_empty) begin
            state_q <= StHalted;
            idle_q  <= 1'b1;
          end
        end
        StHalted: begin
          if (!drain_req) begin
            state_q <= StRun;
            idle_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= StRun;
          idle_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic        drain_start;

  assign drain_start = (state_q == StRun) && drain_req;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (drain_start) begin
      stall_cnt_d = '0;
    end else if (hazard && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
`endif

  assign addr_a     = dec_q.ra;
  assign addr_b     = dec_q.rb;
  assign imm        = {{(LENGTH-ImmW){dec_q.imm16[ImmW-1]}}, dec_q.imm16};
  assign sel_imm    = dec_q.f;
  assign alu_f      = alu_q.f;
  assign addr_d     = wr_rd_q;
  assign wr_regfile = wr_valid_q;
  assign stall      = hazard;
  assign idle       = idle_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table, drain/reset sequences and
// randomized traffic against a register-busy scoreboard model.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic [31:0] instr;
  logic        drain_req;
  logic        instr_ready;
  logic        idle;
  logic [4:0]  addr_a;
  logic [4:0]  addr_b;
  logic [31:0] imm;
  logic        sel_imm;
  logic        alu_f;
  logic [4:0]  addr_d;
  logic        wr_regfile;
  logic        stall;
`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  pipe_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .drain_req   (drain_req),
    .idle        (idle),
    .addr_a      (addr_a),
    .addr_b      (addr_b),
    .imm         (imm),
    .sel_imm     (sel_imm),
    .alu_f       (alu_f),
    .addr_d      (addr_d),
    .wr_regfile  (wr_regfile),
    .stall       (stall)
`ifdef PIPE_CTRL_STALL_CNT_EN
    ,
    .stall_count (stall_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk(input bit f, input int rd, input int ra, input int rb,
                                     input int imm16);
    logic [31:0] w;
    w = {f, rd[4:0], ra[4:0], rb[4:0], imm16[15:0]};
    return w;
  endfunction

  // Model: a register is busy until the edge its pending write lands; writes and
  // ALU-stage functions are scheduled by cycle number.
  int          cyc;
  bit          m_dec_has;
  logic [31:0] m_dec_ins;
  int          land [32];
  bit          m_wr_at [int];
  int          m_wr_rd [int];
  bit          m_af_at [int];
  int          m_mode;   // 0 run, 1 drain, 2 halted
  int          m_cnt;
  bit          m_haz;
  bit          m_ready;
  bit          cur_v;
  logic [31:0] cur_ins;
  bit          cur_dr;

  task automatic model_reset();
    cyc       = 0;
    m_dec_has = 0;
    m_dec_ins = '0;
    for (int i = 0; i < 32; i++) land[i] = -1;
    m_wr_at.delete();
    m_wr_rd.delete();
    m_af_at.delete();
    m_mode = 0;
    m_cnt  = 0;
  endtask

  task automatic model_eval(input bit dr);
    int ra;
    int rb;
    ra      = int'(m_dec_ins[25:21]);
    rb      = int'(m_dec_ins[20:16]);
    m_haz   = m_dec_has && ((land[ra] > cyc) || (!m_dec_ins[31] && (land[rb] > cyc)));
    m_ready = (m_mode == 0) && !dr && !m_haz;
  endtask

  task automatic model_check();
    bit          e_wr;
    bit          e_af;
    logic [31:0] e_imm;
    e_wr  = m_wr_at.exists(cyc);
    e_af  = m_af_at.exists(cyc) ? m_af_at[cyc] : 1'b0;
    e_imm = {{16{m_dec_ins[15]}}, m_dec_ins[15:0]};
    check("ready", instr_ready, m_ready);
    check("stall", stall, m_haz);
    check("wr_regfile", wr_regfile, e_wr);
    if (e_wr) check("addr_d", addr_d, m_wr_rd[cyc]);
    check("alu_f", alu_f, e_af);
    check("addr_a", addr_a, m_dec_ins[25:21]);
    check("addr_b", addr_b, m_dec_ins[20:16]);
    check("sel_imm", sel_imm, m_dec_ins[31]);
    check("imm", imm, e_imm);
    check("idle", idle, m_mode == 2);
`ifdef PIPE_CTRL_STALL_CNT_EN
    check("stall_count", stall_count, m_cnt);
`endif
  endtask

  task automatic model_advance(input bit v, input logic [31:0] ins, input bit dr);
    bit acc;
    bit empty;
    int rd;
    acc   = v && m_ready;
    empty = !m_dec_has && !m_wr_at.exists(cyc) && !m_wr_at.exists(cyc + 1);
    if (!m_haz && m_dec_has) begin
      rd                = int'(m_dec_ins[30:26]);
      m_wr_at[cyc + 2]  = 1'b1;
      m_wr_rd[cyc + 2]  = rd;
      m_af_at[cyc + 1]  = m_dec_ins[31];
      land[rd]          = cyc + 3;
    end
    if (!m_haz) begin
      m_dec_has = acc;
      if (acc) m_dec_ins = ins;
    end
    if (m_mode == 0 && dr) m_cnt = 0;
    else if (m_haz && m_cnt < 65535) m_cnt++;
    case (m_mode)
      0: if (dr) m_mode = 1;
      1: if (!dr) m_mode = 0; else if (empty) m_mode = 2;
      default: if (!dr) m_mode = 0;
    endcase
    cyc++;
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input bit dr);
    @(negedge clk);
    instr_valid = v;
    instr       = ins;
    drain_req   = dr;
    cur_v       = v;
    cur_ins     = ins;
    cur_dr      = dr;
    #1;
    model_eval(dr);
    model_check();
  endtask

  task automatic tick();
    model_advance(cur_v, cur_ins, cur_dr);
    @(posedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, instr_ready, 0);
    check({tag, "_idle"}, idle, 0);
    check({tag, "_addr_a"}, addr_a, 0);
    check({tag, "_addr_b"}, addr_b, 0);
    check({tag, "_imm"}, imm, 0);
    check({tag, "_sel_imm"}, sel_imm, 0);
    check({tag, "_alu_f"}, alu_f, 0);
    check({tag, "_addr_d"}, addr_d, 0);
    check({tag, "_wr"}, wr_regfile, 0);
    check({tag, "_stall"}, stall, 0);
`ifdef PIPE_CTRL_STALL_CNT_EN
    check({tag, "_stall_count"}, stall_count, 0);
`endif
  endtask

  typedef struct {
    bit          v;
    logic [31:0] ins;
    bit          e_ready;
    bit          e_stall;
    bit          e_wr;
    int          e_ad;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input bit v, input logic [31:0] ins, input bit er, input bit es,
                     input bit ew, input int ead);
    vec_t r;
    r.v = v; r.ins = ins; r.e_ready = er; r.e_stall = es; r.e_wr = ew; r.e_ad = ead;
    tbl.push_back(r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k;
    bit  seen_idle;
    bit  dr;

    // Independent back-to-back issue
    add(1, mk(0, 1, 10, 10, 0), 1, 0, 0, 0);
    add(1, mk(0, 2, 10, 10, 0), 1, 0, 0, 0);
    add(1, mk(0, 3, 10, 10, 0), 1, 0, 0, 0);
    add(1, mk(0, 4, 10, 10, 0), 1, 0, 1, 1);
    add(0, 32'h0, 1, 0, 1, 2);
    add(0, 32'h0, 1, 0, 1, 3);
    add(0, 32'h0, 1, 0, 1, 4);
    add(0, 32'h0, 1, 0, 0, 0);
    // Distance-1 dependency on ra: two stall cycles
    add(1, mk(0, 5, 10, 10, 0), 1, 0, 0, 0);
    add(1, mk(0, 6, 5, 10, 0), 1, 0, 0, 0);
    add(0, 32'h0, 0, 1, 0, 0);
    add(0, 32'h0, 0, 1, 1, 5);
    add(0, 32'h0, 1, 0, 0, 0);
    add(0, 32'h0, 1, 0, 0, 0);
    add(0, 32'h0, 1, 0, 1, 6);
    // Distance-2 dependency on rb with f = 0: one stall cycle
    add(1, mk(0, 7, 10, 10, 0), 1, 0, 0, 0);
    add(1, mk(0, 8, 11, 11, 0), 1, 0, 0, 0);
    add(1, mk(0, 9, 12, 7, 0), 1, 0, 0, 0);
    add(0, 32'h0, 0, 1, 1, 7);
    add(0, 32'h0, 1, 0, 1, 8);
    add(0, 32'h0, 1, 0, 0, 0);
    add(0, 32'h0, 1, 0, 1, 9);
    // Same with f = 1: rb ignored, no stall
    add(1, mk(0, 7, 10, 10, 0), 1, 0, 0, 0);
    add(1, mk(0, 8, 11, 11, 0), 1, 0, 0, 0);
    add(1, mk(1, 9, 12, 7, 16'hFF80), 1, 0, 0, 0);
    add(0, 32'h0, 1, 0, 1, 7);
    add(0, 32'h0, 1, 0, 1, 8);
    add(0, 32'h0, 1, 0, 1, 9);

    instr_valid = 0;
    instr       = '0;
    drain_req   = 0;
    reset       = 1;
    #2;
    reset = 0;
    #1;
    check_all_zero("reset");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1;

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].ins, 1'b0);
      check($sformatf("vec%0d_ready", i), instr_ready, tbl[i].e_ready);
      check($sformatf("vec%0d_stall", i), stall, tbl[i].e_stall);
      check($sformatf("vec%0d_wr", i), wr_regfile, tbl[i].e_wr);
      if (tbl[i].e_wr) check($sformatf("vec%0d_addr_d", i), addr_d, tbl[i].e_ad);
      tick();
    end
    drive(0, 32'h0, 0);
    check("held_imm", imm, 32'hFFFF_FF80);
    check("held_sel_imm", sel_imm, 1);
`ifdef PIPE_CTRL_STALL_CNT_EN
    check("stall_count_after_deps", stall_count, 3);
`endif
    tick();

    // Drain with three instructions in flight
    for (int i = 1; i <= 3; i++) begin
      drive(1, mk(0, i, 20, 20, 0), 0);
      tick();
    end
    k         = 0;
    seen_idle = 0;
    while (!seen_idle && k < 20) begin
      drive(0, 32'h0, 1);
      if (k == 0) check("drain_ready_immediate", instr_ready, 0);
      if (idle) seen_idle = 1;
      else begin
        tick();
        k++;
      end
    end
    check("drain_idle_reached", seen_idle, 1);
    check("drain_idle_cycle", k, 4);
`ifdef PIPE_CTRL_STALL_CNT_EN
    check("stall_count_cleared", stall_count, 0);
`endif
    tick();
    drive(0, 32'h0, 0);
    tick();
    drive(0, 32'h0, 0);
    check("resume_ready", instr_ready, 1);
    check("resume_idle", idle, 0);
    tick();

    // Reset with writes pending
    drive(1, mk(0, 3, 1, 2, 16'h1234), 0);
    tick();
    drive(1, mk(1, 4, 5, 6, 16'h8001), 0);
    tick();
    drive(0, 32'h0, 0);
    #2;
    reset = 0;
    #1;
    check_all_zero("midreset");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 32'h0, 0);
      check("post_reset_no_write", wr_regfile, 0);
      tick();
    end

    // Randomized traffic over a small register window to provoke hazards
    dr = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(23, 0) == 0) dr = !dr;
      drive($urandom_range(3, 0) != 0,
            mk($urandom_range(1, 0) == 1, $urandom_range(7, 0), $urandom_range(7, 0),
               $urandom_range(7, 0), $urandom_range(65535, 0)),
            dr);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
